// File: rtl/learning_neuron_seq.sv
// Sequential learning neuron: a serial multiply-accumulate forward pass
// followed, on request, by a serial backprop pass that returns per-input
// error terms and applies a shift-scaled gradient step to weights and bias.
// Values are signed fixed point with FRAC_W fractional bits. Every
// accumulation and weight write saturates to the signed DATA_W range.
module learning_neuron_seq #(
  parameter int N_INPUTS = 32,
  parameter int DATA_W   = 32,
  parameter int FRAC_W   = 16,
  parameter int ACT_MODE = 0,
  parameter logic signed [DATA_W-1:0] INIT_W = DATA_W'(64'sd1 <<< FRAC_W)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fwd_start,
  input  logic [N_INPUTS*DATA_W-1:0] in_data,
  input  logic [N_INPUTS-1:0]        enabled,
  input  logic                       bp_start,
  input  logic [DATA_W-1:0]          bp_err,
  input  logic [4:0]                 lr_shift,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  output logic [N_INPUTS*DATA_W-1:0] back_data,
  output logic                       back_valid,
  output logic                       busy
);

  // k runs 0..N_INPUTS. The extra value N_INPUTS is the wrap-up step that
  // publishes the result, which gives the N_INPUTS+1 cycle latency.
  localparam int KW = $clog2(N_INPUTS + 1);
  localparam int IW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  // Products need 2*DATA_W bits. Two guard bits keep the sums that follow
  // from overflowing before they are saturated.
  localparam int WW = 2 * DATA_W + 2;

  localparam logic [KW-1:0] K_END = KW'(N_INPUTS);

  typedef logic signed [DATA_W-1:0] word_t;
  typedef logic signed [WW-1:0]     wide_t;

  localparam wide_t SAT_MAX = (wide_t'(1) <<< (DATA_W - 1)) - wide_t'(1);
  localparam wide_t SAT_MIN = -(wide_t'(1) <<< (DATA_W - 1));

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FWD  = 2'd1,
    S_BWD  = 2'd2
  } state_t;

  // Clamp a wide intermediate into the signed word range.
  function automatic word_t sat(input wide_t v);
    if (v > SAT_MAX)      return {1'b0, {(DATA_W-1){1'b1}}};
    else if (v < SAT_MIN) return {1'b1, {(DATA_W-1){1'b0}}};
    else                  return v[DATA_W-1:0];
  endfunction

  function automatic logic non_positive(input word_t a);
    return a[DATA_W-1] || (a == '0);
  endfunction

  // ReLU passes only strictly positive values. Identity passes everything.
  function automatic word_t act(input word_t a);
    if (ACT_MODE == 1 && non_positive(a)) return '0;
    return a;
  endfunction

  // Architectural state
  state_t            state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  word_t             x_q [N_INPUTS];
  word_t             x_d [N_INPUTS];
  logic [N_INPUTS-1:0] en_q, en_d;
  word_t             acc_q, acc_d;
  word_t             preact_q, preact_d;
  word_t             delta_q, delta_d;
  logic [4:0]        lr_q, lr_d;
  word_t             w_q [N_INPUTS];
  word_t             w_d [N_INPUTS];
  word_t             bias_q, bias_d;
  word_t             out_q, out_d;
  word_t             back_q [N_INPUTS];
  word_t             back_d [N_INPUTS];
  logic              fwd_done_q, fwd_done_d;
  logic              out_valid_q, out_valid_d;
  logic              back_valid_q, back_valid_d;

  // Per-step datapath operands
  logic [IW-1:0]     k_idx;
  word_t             x_k, w_k;
  logic              en_k;
  logic [6:0]        upd_sh;
  wide_t             fwd_term, back_term, upd_term, bias_term;

  // Select operand k and form the scaled products used by both passes.
  always_comb begin
    // On the wrap-up step (k == N_INPUTS) point at a legal element. Nothing
    // read there is used.
    k_idx     = (k_q < K_END) ? k_q[IW-1:0] : '0;
    x_k       = x_q[k_idx];
    w_k       = w_q[k_idx];
    en_k      = en_q[k_idx];
    upd_sh    = 7'(FRAC_W) + 7'(lr_q);
    // Signed operands make >>> an arithmetic shift, which rounds toward
    // minus infinity.
    fwd_term  = (wide_t'(x_k) * wide_t'(w_k)) >>> FRAC_W;
    back_term = (wide_t'(delta_q) * wide_t'(w_k)) >>> FRAC_W;
    upd_term  = (wide_t'(delta_q) * wide_t'(x_k)) >>> upd_sh;
    bias_term = wide_t'(delta_q) >>> lr_q;
  end

  // Next-state logic for the FSM and every datapath register.
  always_comb begin
    // NOTE: every _d starts from its hold value, so a branch that skips
    // assigning a _d cannot infer a latch.
    state_d      = state_q;
    k_d          = k_q;
    x_d          = x_q;
    en_d         = en_q;
    acc_d        = acc_q;
    preact_d     = preact_q;
    delta_d      = delta_q;
    lr_d         = lr_q;
    w_d          = w_q;
    bias_d       = bias_q;
    out_d        = out_q;
    back_d       = back_q;
    fwd_done_d   = fwd_done_q;
    out_valid_d  = 1'b0;
    back_valid_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // A backprop request wins, but only after a completed forward
        // pass. Otherwise a forward request still gets through.
        if (bp_start && fwd_done_q) begin
          state_d = S_BWD;
          k_d     = '0;
          lr_d    = lr_shift;
          delta_d = (ACT_MODE == 1 && non_positive(preact_q)) ? '0 : word_t'(bp_err);
        end else if (fwd_start) begin
          state_d = S_FWD;
          k_d     = '0;
          en_d    = enabled;
          acc_d   = bias_q;
          for (int i = 0; i < N_INPUTS; i++) begin
            x_d[i] = in_data[i*DATA_W +: DATA_W];
          end
        end
      end

      S_FWD: begin
        if (k_q == K_END) begin
          preact_d    = acc_q;
          out_d       = act(acc_q);
          out_valid_d = 1'b1;
          fwd_done_d  = 1'b1;
          state_d     = S_IDLE;
        end else begin
          if (en_k) acc_d = sat(wide_t'(acc_q) + fwd_term);
          k_d = k_q + 1'b1;
        end
      end

      S_BWD: begin
        if (k_q == K_END) begin
          bias_d       = sat(wide_t'(bias_q) + bias_term);
          back_valid_d = 1'b1;
          fwd_done_d   = 1'b0;
          state_d      = S_IDLE;
        end else begin
          // back_term uses the weight as it was before this step's update.
          back_d[k_idx] = en_k ? sat(back_term) : '0;
          if (en_k) w_d[k_idx] = sat(wide_t'(w_k) + upd_term);
          k_d = k_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset. Reset overrides any start request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      k_q          <= '0;
      en_q         <= '0;
      acc_q        <= '0;
      preact_q     <= '0;
      delta_q      <= '0;
      lr_q         <= '0;
      bias_q       <= '0;
      out_q        <= '0;
      fwd_done_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      back_valid_q <= 1'b0;
      // NOTE: the weight array lives in flops, not RAM, so it can be reset.
      // Reset is how it gets its INIT_W starting point.
      for (int i = 0; i < N_INPUTS; i++) begin
        x_q[i]    <= '0;
        w_q[i]    <= INIT_W;
        back_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments let every register see the
      // pre-edge values of the others.
      state_q      <= state_d;
      k_q          <= k_d;
      x_q          <= x_d;
      en_q         <= en_d;
      acc_q        <= acc_d;
      preact_q     <= preact_d;
      delta_q      <= delta_d;
      lr_q         <= lr_d;
      w_q          <= w_d;
      bias_q       <= bias_d;
      out_q        <= out_d;
      back_q       <= back_d;
      fwd_done_q   <= fwd_done_d;
      out_valid_q  <= out_valid_d;
      back_valid_q <= back_valid_d;
    end
  end

  // Pack the per-input backprop registers onto the output bus.
  always_comb begin
    back_data = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      back_data[i*DATA_W +: DATA_W] = back_q[i];
    end
  end

  assign out_data   = out_q;
  assign out_valid  = out_valid_q;
  assign back_valid = back_valid_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_learning_neuron_seq.sv
// Directed bench for learning_neuron_seq (N_INPUTS=4, DATA_W=32, FRAC_W=16).
// An identity-activation instance and a ReLU instance share the same stimulus.
// Expected values are hand-computed Q16.16 results.
module tb_learning_neuron_seq;

  localparam int N  = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          fwd_start;
  logic          bp_start;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]  enabled;
  logic [DW-1:0] bp_err;
  logic [4:0]    lr_shift;

  logic [DW-1:0]   out_data, out_data_r;
  logic            out_valid, out_valid_r;
  logic [N*DW-1:0] back_data, back_data_r;
  logic            back_valid, back_valid_r;
  logic            busy, busy_r;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  learning_neuron_seq #(.N_INPUTS(N), .DATA_W(DW), .FRAC_W(16), .ACT_MODE(0)) dut (
    .clk(clk), .rst(rst), .fwd_start(fwd_start), .in_data(in_data), .enabled(enabled),
    .bp_start(bp_start), .bp_err(bp_err), .lr_shift(lr_shift),
    .out_data(out_data), .out_valid(out_valid), .back_data(back_data),
    .back_valid(back_valid), .busy(busy)
  );

  learning_neuron_seq #(.N_INPUTS(N), .DATA_W(DW), .FRAC_W(16), .ACT_MODE(1)) dut_relu (
    .clk(clk), .rst(rst), .fwd_start(fwd_start), .in_data(in_data), .enabled(enabled),
    .bp_start(bp_start), .bp_err(bp_err), .lr_shift(lr_shift),
    .out_data(out_data_r), .out_valid(out_valid_r), .back_data(back_data_r),
    .back_valid(back_valid_r), .busy(busy_r)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle, so samples land away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] bslice(input logic [N*DW-1:0] v, input int k);
    return v[k*DW +: DW];
  endfunction

  task automatic set_x(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [31:0] d);
    in_data = {d, c, b, a};
  endtask

  // Launch a forward pass. Returns the cycles from acceptance to out_valid
  // (0 if it never came).
  task automatic run_fwd(output int lat);
    fwd_start = 1'b1;
    tick();
    fwd_start = 1'b0;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (out_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic run_bp(output int lat);
    bp_start = 1'b1;
    tick();
    bp_start = 1'b0;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (back_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  initial begin
    int   lat;
    logic seen;

    rst = 1'b1; fwd_start = 1'b0; bp_start = 1'b0;
    in_data = '0; enabled = '0; bp_err = '0; lr_shift = '0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check("rst_busy",       32'(busy), 32'h0);
    check("rst_out_valid",  32'(out_valid), 32'h0);
    check("rst_back_valid", 32'(back_valid), 32'h0);
    check("rst_out_data",   out_data, 32'h0);
    check("rst_back0",      bslice(back_data, 0), 32'h0);
    check("rst_back3",      bslice(back_data, 3), 32'h0);

    // Backprop with no prior forward pass is ignored
    bp_err = 32'hFFFF0000; lr_shift = 5'd0;
    bp_start = 1'b1;
    tick();
    bp_start = 1'b0;
    check("nofwd_bp_busy", 32'(busy), 32'h0);
    seen = 1'b0;
    repeat (8) begin
      tick();
      if (back_valid || busy) seen = 1'b1;
    end
    check("nofwd_bp_no_activity", 32'(seen), 32'h0);

    // First forward: only x0 enabled, so the masked 2.0 inputs must not count
    set_x(32'h00010000, 32'h00020000, 32'h00020000, 32'h00020000);
    enabled = 4'b0001;
    fwd_start = 1'b1;
    tick();
    fwd_start = 1'b0;
    check("fwd1_busy_after_accept", 32'(busy), 32'h1);
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (out_valid) begin
        lat = c;
        break;
      end
    end
    check("fwd1_latency",  32'(lat), 32'd5);
    check("fwd1_out",      out_data, 32'h00010000);
    check("fwd1_out_relu", out_data_r, 32'h00010000);
    check("fwd1_idle_at_valid", 32'(busy), 32'h0);
    tick();
    check("fwd1_valid_pulse", 32'(out_valid), 32'h0);
    check("fwd1_out_hold",    out_data, 32'h00010000);

    // Backprop of -1.0. Live in_data changes must not affect the weight update.
    set_x(32'h00030000, 32'h00030000, 32'h00030000, 32'h00030000);
    bp_err = 32'hFFFF0000; lr_shift = 5'd0;
    run_bp(lat);
    check("bp1_latency", 32'(lat), 32'd5);
    check("bp1_back0",   bslice(back_data, 0), 32'hFFFF0000);
    check("bp1_back1",   bslice(back_data, 1), 32'h0);
    check("bp1_back2",   bslice(back_data, 2), 32'h0);
    check("bp1_back3",   bslice(back_data, 3), 32'h0);
    check("bp1_back0_relu", bslice(back_data_r, 0), 32'hFFFF0000);

    // Repeat forward: w0 = 0 and bias = -1.0
    set_x(32'h00010000, 32'h00020000, 32'h00020000, 32'h00020000);
    run_fwd(lat);
    check("fwd2_latency",  32'(lat), 32'd5);
    check("fwd2_out",      out_data, 32'hFFFF0000);
    check("fwd2_out_relu", out_data_r, 32'h0);

    // Simultaneous starts: backprop wins; a forward start during BWD is dropped.
    // Identity: delta = +1.0, lr = 1, latched x0 = 1.0 -> w0 = 0.5, bias = -0.5.
    set_x(32'h00050000, 32'h00050000, 32'h00050000, 32'h00050000);
    bp_err = 32'h00010000; lr_shift = 5'd1;
    bp_start = 1'b1; fwd_start = 1'b1;
    tick();
    bp_start = 1'b0; fwd_start = 1'b0;
    check("both_busy", 32'(busy), 32'h1);
    lat = 0; seen = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      fwd_start = (c == 2);
      tick();
      if (out_valid) seen = 1'b1;
      if (back_valid) begin
        lat = c;
        break;
      end
    end
    fwd_start = 1'b0;
    check("both_bwd_latency", 32'(lat), 32'd5);
    repeat (8) begin
      tick();
      if (out_valid || busy) seen = 1'b1;
    end
    check("both_fwd_ignored", 32'(seen), 32'h0);
    check("both_back0", bslice(back_data, 0), 32'h0);

    // Forward with x0 = 2.0: -0.5 + 0.5*2.0 = 0.5. The ReLU copy keeps w0=0 and bias=-1.0.
    set_x(32'h00020000, 32'h0, 32'h0, 32'h0);
    enabled = 4'b0001;
    run_fwd(lat);
    check("fwd3_out",      out_data, 32'h00008000);
    check("fwd3_out_relu", out_data_r, 32'h0);

    // Saturation, positive and negative
    rst = 1'b1; tick(); rst = 1'b0;
    set_x(32'h7FFF0000, 32'h7FFF0000, 32'h7FFF0000, 32'h7FFF0000);
    enabled = 4'hF;
    run_fwd(lat);
    check("sat_pos",      out_data, 32'h7FFFFFFF);
    check("sat_pos_relu", out_data_r, 32'h7FFFFFFF);
    set_x(32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000);
    run_fwd(lat);
    check("sat_neg",      out_data, 32'h80000000);
    check("sat_neg_relu", out_data_r, 32'h0);

    // Arithmetic shift rounding toward minus infinity
    set_x(32'hFFFFFFFF, 32'h0, 32'h0, 32'h0);
    enabled = 4'b0001;
    run_fwd(lat);
    check("rnd_fwd_out", out_data, 32'hFFFFFFFF);
    bp_err = 32'hFFFFFFFF; lr_shift = 5'd3;
    run_bp(lat);
    check("rnd_back0", bslice(back_data, 0), 32'hFFFFFFFF);
    // bias = -1 >>> 3 = -1 and w0 stays 1.0, so the next output is 0xFFFF
    set_x(32'h00010000, 32'h0, 32'h0, 32'h0);
    run_fwd(lat);
    check("rnd_bias_w0", out_data, 32'h0000FFFF);

    // Masked multi-input update
    rst = 1'b1; tick(); rst = 1'b0;
    set_x(32'h00010000, 32'h00020000, 32'h00030000, 32'h00040000);
    enabled = 4'b0101;
    run_fwd(lat);
    check("mask_fwd_out", out_data, 32'h00040000);
    bp_err = 32'h00008000; lr_shift = 5'd0;
    run_bp(lat);
    check("mask_back0", bslice(back_data, 0), 32'h00008000);
    check("mask_back1", bslice(back_data, 1), 32'h0);
    check("mask_back2", bslice(back_data, 2), 32'h00008000);
    check("mask_back3", bslice(back_data, 3), 32'h0);
    // 0.5 + 1.5*1.0 + 2.5*3.0 = 9.5
    run_fwd(lat);
    check("mask_fwd2",      out_data, 32'h00098000);
    check("mask_fwd2_relu", out_data_r, 32'h00098000);
    // w1 and w3 untouched: 0.5 + 1.0 + 1.0 = 2.5
    set_x(32'h0, 32'h00010000, 32'h0, 32'h00010000);
    enabled = 4'hF;
    run_fwd(lat);
    check("mask_unchanged_w", out_data, 32'h00028000);
    check("back_hold",        bslice(back_data, 0), 32'h00008000);

    // Reset in the middle of a forward pass
    rst = 1'b1; tick(); rst = 1'b0;
    set_x(32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000);
    enabled = 4'hF;
    fwd_start = 1'b1;
    tick();
    fwd_start = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    check("midrst_busy",     32'(busy), 32'h0);
    check("midrst_out_data", out_data, 32'h0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("midrst_no_out_valid", 32'(seen), 32'h0);
    run_fwd(lat);
    check("midrst_weights_init", out_data, 32'h00040000);

    // Reset takes priority over a start in the same cycle, and clears fwd_done
    rst = 1'b1; fwd_start = 1'b1;
    tick();
    rst = 1'b0; fwd_start = 1'b0;
    check("rst_vs_start_busy", 32'(busy), 32'h0);
    bp_start = 1'b1;
    tick();
    bp_start = 1'b0;
    check("rst_clears_fwd_done", 32'(busy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Safety net against a wedged simulation
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/learning_neuron_seq.md
LEARNING_NEURON_SEQ -- requirements
Module: learning_neuron_seq

Interface
REQ-001 SHALL have parameter N_INPUTS, default 32, number of synaptic inputs (>=1).
REQ-002 SHALL have parameter DATA_W, default 32, signed fixed-point word width.
REQ-003 SHALL have parameter FRAC_W, default 16, fractional bits (1.0 = 1<<FRAC_W).
REQ-004 SHALL have parameter ACT_MODE, default 0, activation: 0 identity, 1 ReLU.
REQ-005 SHALL have parameter INIT_W, default 1<<FRAC_W, reset value of every weight.
REQ-006 SHALL use one clock and a synchronous, active-high reset: clk (input, 1, rising-edge clock) and rst (input, 1, synchronous active-high reset).
REQ-007 SHALL have port: fwd_start  input  1  request forward pass.
REQ-008 SHALL have port: in_data  input  N_INPUTS*DATA_W  packed signed inputs, x[k] at bits [k*DATA_W +: DATA_W].
REQ-009 SHALL have port: enabled  input  N_INPUTS  per-input enable mask.
REQ-010 SHALL have port: bp_start  input  1  request backprop/update.
REQ-011 SHALL have port: bp_err  input  DATA_W  signed error (expected minus actual).
REQ-012 SHALL have port: lr_shift  input  5  learning rate = 2^-lr_shift.
REQ-013 SHALL have port: out_data  output  DATA_W  activated neuron output.
REQ-014 SHALL have port: out_valid  output  1  one-cycle pulse, out_data updated.
REQ-015 SHALL have port: back_data  output  N_INPUTS*DATA_W  per-input backpropagated error.
REQ-016 SHALL have port: back_valid  output  1  one-cycle pulse, back_data/weights updated.
REQ-017 SHALL have port: busy  output  1  high when not IDLE.

Function
REQ-018 SHALL implement FSM IDLE, FWD, BWD; busy=1 in FWD/BWD.
REQ-019 In IDLE, bp_start SHALL take priority over simultaneous fwd_start; starts outside IDLE SHALL be ignored.
REQ-020 bp_start SHALL be ignored unless a forward pass completed since reset (fwd_done flag).
REQ-021 On fwd_start accept: latch in_data and enabled, acc=bias, k=0, enter FWD.
REQ-022 Each FWD cycle SHALL process index k: if enabled[k], acc += (x[k]*w[k])>>>FRAC_W; k++.
REQ-023 Products SHALL be computed at 2*DATA_W; accumulator SHALL saturate to signed DATA_W range each step.
REQ-024 After index N_INPUTS-1: store preact=acc, out_data=act(acc), pulse out_valid, set fwd_done, return IDLE; out_valid asserts N_INPUTS+1 cycles after fwd_start accepted.
REQ-025 ReLU: act(a)=a if a>0 else 0; identity: act(a)=a.
REQ-026 On bp_start accept: latch delta=bp_err (ReLU and preact<=0: delta=0), k=0, enter BWD.
REQ-027 Each BWD cycle k: back[k] = enabled[k] ? sat((delta*w_old[k])>>>FRAC_W) : 0; w[k] = sat(w[k] + ((delta*x[k])>>>(FRAC_W+lr_shift))) if enabled[k], else unchanged.
REQ-028 Weight update SHALL use latched forward inputs, not live in_data.
REQ-029 Bias SHALL update once in BWD: bias = sat(bias + (delta>>>lr_shift)).
REQ-030 After index N_INPUTS-1: pulse back_valid, clear fwd_done, return IDLE; latency N_INPUTS+1 cycles.
REQ-031 Shifts SHALL be arithmetic (round toward minus infinity); lr_shift SHALL be latched at bp_start.
REQ-032 out_data and back_data SHALL hold their values between passes.

Reset
REQ-033 rst SHALL, at any state including mid-pass, force IDLE, all weights=INIT_W, bias=0, out_data=0, back_data=0, out_valid=0, back_valid=0, busy=0, fwd_done=0.
REQ-034 rst SHALL take priority over fwd_start/bp_start in the same cycle.

Verification (N_INPUTS=4, DATA_W=32, FRAC_W=16)
REQ-035 ACT_MODE=0, x0=0x10000, enabled=4'b0001, fwd_start -> out_valid 5 cycles later, out_data=0x10000.
REQ-036 Then bp_err=0xFFFF0000 (-1.0), lr_shift=0, bp_start -> back_valid 5 cycles later, back[0]=0xFFFF0000, back[1..3]=0, w0=0, bias=0xFFFF0000; repeat forward -> out_data=0xFFFF0000 (ACT_MODE=1: 0).
REQ-037 All x=0x7FFF0000, enabled=4'hF -> out_data=0x7FFFFFFF (saturated).
REQ-038 bp_start after reset with no forward pass -> busy stays 0, no back_valid, weights unchanged.
REQ-039 rst asserted 2 cycles into FWD -> next cycle busy=0, out_valid never pulses, weights=0x10000.
REQ-040 fwd_start and bp_start together in IDLE with fwd_done=1 -> BWD entered; fwd_start pulsed during BWD ignored.
